pmem_arbiter: RTL and testbench

- Two-client arbiter between the instruction cache and the data cache miss/writeback ports and the single shared physical-memory port.
- Sits directly downstream of each cache_control instance.
- Grants one cache at a time, registers that cache's line request, forwards it to physical memory, and routes the response back only to the granted cache.

---
 rtl/pmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_pmem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - two-client icache/dcache arbiter onto the shared physical-memory port
// Optional feature: define PMEM_ARB_RR_EN for round-robin arbitration between the two caches.
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction cache
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  // data cache
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  // physical memory
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_TURN    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-3){1'b1}}, 3'b000};

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_op_wr;
  logic              r_pmem_read;
  logic              r_pmem_write;

  logic              w_d_req;
  logic              w_pick_d;
  logic              w_grant_i;
  logic              w_grant_d;

`ifdef PMEM_ARB_RR_EN
  // 1 = dcache was granted last, 0 = icache was granted last
  logic              r_last_grant;
`endif

  // Winner selection for the next idle sample; dcache write outranks dcache read via op latch
  always_comb begin
    w_d_req = d_pmem_read | d_pmem_write;
`ifdef PMEM_ARB_RR_EN
    if (w_d_req && i_pmem_read) begin
      w_pick_d = ~r_last_grant;
    end else begin
      w_pick_d = w_d_req;
    end
`else
    w_pick_d = w_d_req;
`endif
  end

  // Arbitration FSM: latch the winner's request, hold strobes until resp, then one dead cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_op_wr      <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
`ifdef PMEM_ARB_RR_EN
      r_last_grant <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_d) begin
            r_state      <= S_GRANT_D;
            r_addr       <= d_pmem_address;
            r_op_wr      <= d_pmem_write;
            r_wdata      <= d_pmem_write ? d_pmem_wdata : '0;
            r_pmem_read  <= ~d_pmem_write;
            r_pmem_write <= d_pmem_write;
`ifdef PMEM_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
          end else if (i_pmem_read) begin
            r_state      <= S_GRANT_I;
            r_addr       <= i_pmem_address;
            r_op_wr      <= 1'b0;
            r_wdata      <= '0;
            r_pmem_read  <= 1'b1;
            r_pmem_write <= 1'b0;
`ifdef PMEM_ARB_RR_EN
            r_last_grant <= 1'b0;
`endif
          end
        end
        S_GRANT_I, S_GRANT_D: begin
          if (pmem_resp) begin
            r_state      <= S_TURN;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
          end else begin
            r_pmem_read  <= ~r_op_wr;
            r_pmem_write <= r_op_wr;
          end
        end
        S_TURN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Response routing goes only to the granted cache, in the same cycle as pmem_resp
  always_comb begin
    w_grant_i    = (r_state == S_GRANT_I);
    w_grant_d    = (r_state == S_GRANT_D);
    i_pmem_resp  = w_grant_i & pmem_resp;
    d_pmem_resp  = w_grant_d & pmem_resp;
    i_pmem_rdata = w_grant_i ? pmem_rdata : '0;
    d_pmem_rdata = w_grant_d ? pmem_rdata : '0;
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_addr & LINE_MASK;
  assign pmem_wdata   = r_wdata;

`ifndef SYNTHESIS
  // A dcache read and write together is a client protocol error; the write is taken
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(d_pmem_read && d_pmem_write));
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - self-checking bench for pmem_arbiter with a transaction-level reference model
module tb_pmem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Reference model: who owns the memory port (0 none, 1 icache, 2 dcache),
  // whether the post-transaction dead cycle is pending, and the captured request.
  int           m_owner = 0;
  bit           m_gap   = 0;
  logic [15:0]  m_addr  = '0;
  logic [127:0] m_wdata = '0;
  bit           m_wr    = 0;
  bit           m_last_d = 0;
  bit           want_d, want_i, take_d;

  always @(negedge rst_n) begin
    m_owner = 0; m_gap = 0; m_addr = '0; m_wdata = '0; m_wr = 0; m_last_d = 0;
  end

  // Every cycle: compare DUT outputs against the model, then advance the model by one clock
  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = 0; m_gap = 0; m_addr = '0; m_wdata = '0; m_wr = 0; m_last_d = 0;
      checkb("rst_pmem_read", pmem_read, 1'b0);
      checkb("rst_pmem_write", pmem_write, 1'b0);
      check("rst_pmem_address", 128'(pmem_address), 128'(0));
      check("rst_pmem_wdata", pmem_wdata, 128'(0));
      checkb("rst_i_resp", i_pmem_resp, 1'b0);
      checkb("rst_d_resp", d_pmem_resp, 1'b0);
      check("rst_i_rdata", i_pmem_rdata, 128'(0));
      check("rst_d_rdata", d_pmem_rdata, 128'(0));
    end else begin
      checkb("m_pmem_read", pmem_read, m_owner != 0 && !m_wr);
      checkb("m_pmem_write", pmem_write, m_owner != 0 && m_wr);
      if (m_owner != 0) begin
        check("m_pmem_address", 128'(pmem_address), 128'(m_addr & 16'hFFF8));
        check("m_pmem_wdata", pmem_wdata, m_wdata);
      end
      checkb("m_i_resp", i_pmem_resp, m_owner == 1 && pmem_resp);
      checkb("m_d_resp", d_pmem_resp, m_owner == 2 && pmem_resp);
      check("m_i_rdata", i_pmem_rdata, (m_owner == 1) ? pmem_rdata : 128'(0));
      check("m_d_rdata", d_pmem_rdata, (m_owner == 2) ? pmem_rdata : 128'(0));
      if (m_owner != 0) begin
        if (pmem_resp) begin
          m_owner = 0;
          m_gap   = 1;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else begin
        want_d = d_pmem_read || d_pmem_write;
        want_i = i_pmem_read;
`ifdef PMEM_ARB_RR_EN
        take_d = want_d && !(want_i && m_last_d);
`else
        take_d = want_d;
`endif
        if (take_d) begin
          m_owner = 2; m_addr = d_pmem_address; m_wr = d_pmem_write;
          m_wdata = d_pmem_write ? d_pmem_wdata : 128'(0);
          m_last_d = 1;
        end else if (want_i) begin
          m_owner = 1; m_addr = i_pmem_address; m_wr = 0; m_wdata = '0;
          m_last_d = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Serve one granted transaction: called 1ns after the grant edge; memory answers on cycle lat
  task automatic run_txn(input int lat, input bit is_d, input bit is_wr, input logic [15:0] ea,
                         input logic [127:0] ewd, input logic [127:0] rd, input bit chg);
    logic [127:0] erd;
    for (int k = 0; k < lat; k++) begin
      if (chg && k == 1) i_pmem_address = 16'h4440;
      erd = (k == lat - 1) ? rd : ~rd;
      pmem_resp  = (k == lat - 1);
      pmem_rdata = erd;
      @(negedge clk);
      checkb("t_pmem_read", pmem_read, !is_wr);
      checkb("t_pmem_write", pmem_write, is_wr);
      check("t_pmem_address", 128'(pmem_address), 128'(ea));
      check("t_pmem_wdata", pmem_wdata, ewd);
      checkb("t_i_resp", i_pmem_resp, !is_d && k == lat - 1);
      checkb("t_d_resp", d_pmem_resp, is_d && k == lat - 1);
      check("t_i_rdata", i_pmem_rdata, is_d ? 128'(0) : erd);
      check("t_d_rdata", d_pmem_rdata, is_d ? erd : 128'(0));
      cyc();
    end
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    @(negedge clk);
    checkb("t_turn_read", pmem_read, 1'b0);
    checkb("t_turn_write", pmem_write, 1'b0);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 16'h1234;
    d_pmem_read = 1'b1; d_pmem_write = 1'b0; d_pmem_address = 16'h0;
    d_pmem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;

    // Reset held two cycles with requests pending, then release with only the icache asking
    repeat (2) cyc();
    d_pmem_read = 1'b0;
    rst_n = 1'b1;
    cyc();
    run_txn(5, 1'b0, 1'b0, 16'h1230, 128'(0), {16{8'hA5}}, 1'b1);

    // Dcache writeback
    i_pmem_read = 1'b0;
    d_pmem_write = 1'b1; d_pmem_address = 16'h2008; d_pmem_wdata = {8{16'hDEAD}};
    cyc(); cyc();
    run_txn(3, 1'b1, 1'b1, 16'h2008, {8{16'hDEAD}}, {4{32'h0BADF00D}}, 1'b0);
    d_pmem_write = 1'b0;

    // Simultaneous icache and dcache reads, each drops its request after its response
    i_pmem_read = 1'b1; i_pmem_address = 16'h5557;
    d_pmem_read = 1'b1; d_pmem_address = 16'h600F;
    cyc(); cyc();
`ifdef PMEM_ARB_RR_EN
    run_txn(4, 1'b0, 1'b0, 16'h5550, 128'(0), {4{32'h11112222}}, 1'b0);
    i_pmem_read = 1'b0;
    cyc(); cyc();
    run_txn(2, 1'b1, 1'b0, 16'h6008, 128'(0), {4{32'h33334444}}, 1'b0);
    d_pmem_read = 1'b0;
`else
    run_txn(2, 1'b1, 1'b0, 16'h6008, 128'(0), {4{32'h33334444}}, 1'b0);
    d_pmem_read = 1'b0;
    cyc(); cyc();
    run_txn(4, 1'b0, 1'b0, 16'h5550, 128'(0), {4{32'h11112222}}, 1'b0);
    i_pmem_read = 1'b0;
`endif

    // Reset in the middle of a dcache grant, then a stray memory response
    d_pmem_read = 1'b1; d_pmem_address = 16'h3000;
    cyc(); cyc();
    @(negedge clk);
    checkb("rm_read_before", pmem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkb("rm_read_dropped", pmem_read, 1'b0);
    d_pmem_read = 1'b0;
    cyc();
    rst_n = 1'b1;
    pmem_resp = 1'b1;
    @(negedge clk);
    checkb("rm_i_resp", i_pmem_resp, 1'b0);
    checkb("rm_d_resp", d_pmem_resp, 1'b0);
    cyc();
    pmem_resp = 1'b0;

    // Randomized traffic, stray responses and occasional resets, all checked by the model
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      i_pmem_read = $urandom_range(0, 1);
      i_pmem_address = 16'($urandom);
      r = $urandom_range(0, 3);
      d_pmem_read  = (r == 1);
      d_pmem_write = (r == 2);
      d_pmem_address = 16'($urandom);
      d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata   = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp    = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
